// File: rtl/sdram_qos_arbiter_pkg.sv
// Shared master-ID tags, bus widths and arbiter state encoding for the SDRAM arbiter slice.
package sdram_pkg;

  localparam int unsigned ADDR_W = 26;
  localparam int unsigned DATA_W = 32;

  typedef logic [3:0] mid_t;

  localparam mid_t MID_NONE   = 4'd0;
  localparam mid_t MID_DCACHE = 4'd1;
  localparam mid_t MID_VGA    = 4'd2;
  localparam mid_t MID_BLITW  = 4'd3;
  localparam mid_t MID_BLITR  = 4'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational 4-way round-robin picker: scans IDs 1..4 starting just after rr_last_i.
module sdram_rr_pick
  import sdram_pkg::*;
(
  input  logic [3:0] req_i,
  input  mid_t       rr_last_i,
  output mid_t       winner_o,
  output logic       found_o
);

  logic [1:0] idx;

  always_comb begin
    winner_o = MID_NONE;
    found_o  = 1'b0;
    idx      = '0;
    // Low two bits of rr_last (1..4) are the zero-based slot of the ID after it.
    for (int unsigned k = 0; k < 4; k++) begin
      idx = rr_last_i[1:0] + 2'(k);
      if (!found_o && req_i[idx]) begin
        found_o  = 1'b1;
        winner_o = {2'b00, idx} + 4'd1;
      end
    end
  end

endmodule

// File: rtl/sdram_qos_arbiter.sv
// Four-master SDRAM arbiter: VGA urgency, dcache anti-starvation, then round-robin.
// Grants are registered and held until the controller completes the owning ID.
module sdram_qos_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              dcache_request,
  input  logic              dcache_write,
  input  logic              dcache_burst,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [DATA_W-1:0] dcache_wdata,
  input  logic [3:0]        dcache_byte_en,
  output logic [DATA_W-1:0] dcache_rdata,
  output logic              dcache_valid,
  output logic              dcache_complete,

  input  logic              vga_request,
  input  logic [ADDR_W-1:0] vga_address,
  input  logic              vga_urgent,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_valid,
  output logic              vga_complete,

  input  logic              blitw_request,
  input  logic [ADDR_W-1:0] blitw_address,
  input  logic [DATA_W-1:0] blitw_wdata,
  input  logic [3:0]        blitw_byte_en,
  output logic              blitw_complete,

  input  logic              blitr_request,
  input  logic [ADDR_W-1:0] blitr_address,
  output logic [DATA_W-1:0] blitr_rdata,
  output logic              blitr_valid,
  output logic              blitr_complete,

  output logic              sdram_request,
  output logic [3:0]        sdram_master,
  output logic              sdram_write,
  output logic              sdram_burst,
  output logic [ADDR_W-1:0] sdram_address,
  output logic [DATA_W-1:0] sdram_wdata,
  output logic [3:0]        sdram_byte_en,
  input  logic [DATA_W-1:0] sdram_rdata,
  input  logic [3:0]        sdram_valid,
  input  logic [3:0]        sdram_complete,

  output logic              protocol_error
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  arb_state_e        state_q, state_d;
  mid_t              owner_q, owner_d;
  mid_t              rr_last_q, rr_last_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              perr_q, perr_d;

  logic [3:0] req_vec;
  mid_t       rr_winner;
  logic       rr_found;
  mid_t       winner;
  logic       starving;
  logic       dcache_grant;

  assign req_vec  = {blitr_request, blitw_request, vga_request, dcache_request};
  assign starving = (wait_cnt_q >= MAX_WAIT_C);

  sdram_rr_pick u_rr_pick (
    .req_i     (req_vec),
    .rr_last_i (rr_last_q),
    .winner_o  (rr_winner),
    .found_o   (rr_found)
  );

  always_comb begin
    winner = MID_NONE;
    if (vga_urgent && vga_request) begin
      winner = MID_VGA;
    end else if (dcache_request && starving) begin
      winner = MID_DCACHE;
    end else if (rr_found) begin
      winner = rr_winner;
    end
  end

  assign dcache_grant = (state_q == ST_IDLE) && (winner == MID_DCACHE);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    perr_d    = perr_q;
    case (state_q)
      ST_IDLE: begin
        if (sdram_complete != MID_NONE) perr_d = 1'b1;
        if (winner != MID_NONE) begin
          state_d   = ST_BUSY;
          owner_d   = winner;
          rr_last_d = winner;
        end
      end
      ST_BUSY: begin
        if (sdram_complete == owner_q) begin
          state_d = ST_IDLE;
          owner_d = MID_NONE;
        end else if (sdram_complete != MID_NONE) begin
          perr_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = MID_NONE;
      end
    endcase
  end

  // Counts only while dcache waits behind another owner; keeps counting through a VGA urgency win.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!dcache_request || dcache_grant) begin
      wait_cnt_d = '0;
    end else if (owner_q != MID_DCACHE && wait_cnt_q != '1) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= MID_NONE;
      rr_last_q  <= MID_BLITR;
      wait_cnt_q <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_last_q  <= rr_last_d;
      wait_cnt_q <= wait_cnt_d;
      perr_q     <= perr_d;
    end
  end

  assign sdram_request  = (state_q == ST_BUSY);
  assign sdram_master   = owner_q;
  assign protocol_error = perr_q;

  always_comb begin
    sdram_write   = 1'b0;
    sdram_burst   = 1'b0;
    sdram_address = '0;
    sdram_wdata   = '0;
    sdram_byte_en = '0;
    case (owner_q)
      MID_DCACHE: begin
        sdram_write   = dcache_write;
        sdram_burst   = dcache_burst;
        sdram_address = dcache_address;
        sdram_wdata   = dcache_wdata;
        sdram_byte_en = dcache_byte_en;
      end
      MID_VGA: begin
        sdram_burst   = 1'b1;
        sdram_address = vga_address;
      end
      MID_BLITW: begin
        sdram_write   = 1'b1;
        sdram_address = blitw_address;
        sdram_wdata   = blitw_wdata;
        sdram_byte_en = blitw_byte_en;
      end
      MID_BLITR: begin
        sdram_burst   = 1'b1;
        sdram_address = blitr_address;
      end
      default: ;
    endcase
  end

  // Response decode ignores the owner: a read's last word may land after its complete.
  assign dcache_valid    = !reset && (sdram_valid == MID_DCACHE);
  assign vga_valid       = !reset && (sdram_valid == MID_VGA);
  assign blitr_valid     = !reset && (sdram_valid == MID_BLITR);
  assign dcache_complete = !reset && (sdram_complete == MID_DCACHE);
  assign vga_complete    = !reset && (sdram_complete == MID_VGA);
  assign blitw_complete  = !reset && (sdram_complete == MID_BLITW);
  assign blitr_complete  = !reset && (sdram_complete == MID_BLITR);

  assign dcache_rdata = dcache_valid ? sdram_rdata : '0;
  assign vga_rdata    = vga_valid    ? sdram_rdata : '0;
  assign blitr_rdata  = blitr_valid  ? sdram_rdata : '0;

endmodule

// File: tb/tb_sdram_qos_arbiter.sv
// Directed bench for sdram_qos_arbiter; the bench plays all four masters and the SDRAM controller.
module tb_sdram_qos_arbiter;

  localparam logic [25:0] DC_ADDR = 26'h0111111;
  localparam logic [31:0] DC_WD   = 32'h11112222;
  localparam logic [3:0]  DC_BE   = 4'h3;
  localparam logic [25:0] VG_ADDR = 26'h0222222;
  localparam logic [25:0] BW_ADDR = 26'h0333333;
  localparam logic [31:0] BW_WD   = 32'h33334444;
  localparam logic [3:0]  BW_BE   = 4'hC;
  localparam logic [25:0] BR_ADDR = 26'h0044444;

  logic        clock, reset;
  logic        dcache_request, dcache_write, dcache_burst;
  logic [25:0] dcache_address;
  logic [31:0] dcache_wdata, dcache_rdata;
  logic [3:0]  dcache_byte_en;
  logic        dcache_valid, dcache_complete;
  logic        vga_request, vga_urgent, vga_valid, vga_complete;
  logic [25:0] vga_address;
  logic [31:0] vga_rdata;
  logic        blitw_request, blitw_complete;
  logic [25:0] blitw_address;
  logic [31:0] blitw_wdata;
  logic [3:0]  blitw_byte_en;
  logic        blitr_request, blitr_valid, blitr_complete;
  logic [25:0] blitr_address;
  logic [31:0] blitr_rdata;
  logic        sdram_request, sdram_write, sdram_burst;
  logic [3:0]  sdram_master, sdram_byte_en, sdram_valid, sdram_complete;
  logic [25:0] sdram_address;
  logic [31:0] sdram_wdata, sdram_rdata;
  logic        protocol_error;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [3:0] cmpl_vec;
  assign cmpl_vec = {blitr_complete, blitw_complete, vga_complete, dcache_complete};

  sdram_qos_arbiter #(.MAX_WAIT(64), .WAIT_W(8)) dut (
    .clock(clock), .reset(reset),
    .dcache_request(dcache_request), .dcache_write(dcache_write), .dcache_burst(dcache_burst),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata), .dcache_byte_en(dcache_byte_en),
    .dcache_rdata(dcache_rdata), .dcache_valid(dcache_valid), .dcache_complete(dcache_complete),
    .vga_request(vga_request), .vga_address(vga_address), .vga_urgent(vga_urgent),
    .vga_rdata(vga_rdata), .vga_valid(vga_valid), .vga_complete(vga_complete),
    .blitw_request(blitw_request), .blitw_address(blitw_address), .blitw_wdata(blitw_wdata),
    .blitw_byte_en(blitw_byte_en), .blitw_complete(blitw_complete),
    .blitr_request(blitr_request), .blitr_address(blitr_address), .blitr_rdata(blitr_rdata),
    .blitr_valid(blitr_valid), .blitr_complete(blitr_complete),
    .sdram_request(sdram_request), .sdram_master(sdram_master), .sdram_write(sdram_write),
    .sdram_burst(sdram_burst), .sdram_address(sdram_address), .sdram_wdata(sdram_wdata),
    .sdram_byte_en(sdram_byte_en), .sdram_rdata(sdram_rdata), .sdram_valid(sdram_valid),
    .sdram_complete(sdram_complete), .protocol_error(protocol_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_reqs();
    dcache_request = 1'b0; vga_request = 1'b0; vga_urgent = 1'b0;
    blitw_request = 1'b0; blitr_request = 1'b0;
    sdram_complete = 4'd0; sdram_valid = 4'd0; sdram_rdata = 32'h0;
    dcache_write = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    clear_reqs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] id);
    check_eq({tag, "_req"}, {31'd0, sdram_request}, 32'd1);
    check_eq({tag, "_mst"}, {28'd0, sdram_master}, {28'd0, id});
  endtask

  task automatic check_fwd(input logic [3:0] id);
    logic [25:0] ea; logic ew, eb; logic [3:0] ebe;
    ea = '0; ew = 1'b0; eb = 1'b1; ebe = 4'h0;
    case (id)
      4'd1: begin ea = DC_ADDR; ew = 1'b1; eb = 1'b0; ebe = DC_BE;
              check_eq("fwd_wdata_dc", sdram_wdata, DC_WD); end
      4'd2: ea = VG_ADDR;
      4'd3: begin ea = BW_ADDR; ew = 1'b1; eb = 1'b0; ebe = BW_BE;
              check_eq("fwd_wdata_bw", sdram_wdata, BW_WD); end
      default: ea = BR_ADDR;
    endcase
    check_eq("fwd_addr", {6'd0, sdram_address}, {6'd0, ea});
    check_eq("fwd_wr_burst_be", {26'd0, sdram_write, sdram_burst, sdram_byte_en}, {26'd0, ew, eb, ebe});
  endtask

  // Drive completion for id now; the next cycle must be the mandatory idle cycle.
  task automatic finish_owner(input logic [3:0] id);
    sdram_complete = id;
    #1;
    check_eq("cmpl_decode", {28'd0, cmpl_vec}, {28'd0, 4'b0001 << (id - 4'd1)});
    @(negedge clock);
    sdram_complete = 4'd0;
    check_eq("idle_req", {31'd0, sdram_request}, 32'd0);
    check_eq("idle_mst", {28'd0, sdram_master}, 32'd0);
  endtask

  // VGA owns; dcache and blitr wait m cycles before VGA completes; arbitration then sees wait_cnt=m+1.
  task automatic starve_trial(input int unsigned m, input logic [3:0] exp);
    do_reset();
    vga_request = 1'b1;
    @(negedge clock);
    expect_grant("st_vga", 4'd2);
    dcache_request = 1'b1;
    blitr_request  = 1'b1;
    repeat (m) @(negedge clock);
    finish_owner(4'd2);
    @(negedge clock);
    expect_grant("st_next", exp);
    if (exp == 4'd1) check_eq("st_wait_clr", {24'd0, dut.wait_cnt_q}, 32'd0);
  endtask

  int unsigned rr_exp[5] = '{1, 2, 3, 4, 1};

  initial begin
    reset = 1'b0;
    clear_reqs();
    dcache_burst = 1'b0; dcache_address = DC_ADDR; dcache_wdata = DC_WD; dcache_byte_en = DC_BE;
    vga_address = VG_ADDR;
    blitw_address = BW_ADDR; blitw_wdata = BW_WD; blitw_byte_en = BW_BE;
    blitr_address = BR_ADDR;

    // Reset: outputs forced quiet even with controller activity on the inputs.
    #2 reset = 1'b1;
    sdram_valid = 4'd1; sdram_rdata = 32'hDEADBEEF; sdram_complete = 4'd1;
    repeat (2) @(negedge clock);
    check_eq("rst_req", {31'd0, sdram_request}, 32'd0);
    check_eq("rst_mst", {28'd0, sdram_master}, 32'd0);
    check_eq("rst_perr", {31'd0, protocol_error}, 32'd0);
    check_eq("rst_dvalid", {31'd0, dcache_valid}, 32'd0);
    check_eq("rst_drdata", dcache_rdata, 32'd0);
    check_eq("rst_cmpl", {28'd0, cmpl_vec}, 32'd0);
    clear_reqs();
    reset = 1'b0;

    // Single dcache transaction: grant one cycle after request.
    @(negedge clock);
    dcache_request = 1'b1;
    @(negedge clock);
    expect_grant("dc", 4'd1);
    check_fwd(4'd1);
    repeat (3) @(negedge clock);
    dcache_request = 1'b0;
    finish_owner(4'd1);
    check_eq("dc_perr", {31'd0, protocol_error}, 32'd0);

    // All four requesting continuously: round-robin 1,2,3,4,1 with one idle cycle between.
    do_reset();
    dcache_request = 1'b1; vga_request = 1'b1; blitw_request = 1'b1; blitr_request = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      expect_grant("rr", 4'(rr_exp[i]));
      check_fwd(4'(rr_exp[i]));
      repeat (2) @(negedge clock);
      finish_owner(4'(rr_exp[i]));
    end
    check_eq("rr_perr", {31'd0, protocol_error}, 32'd0);

    // Starvation threshold: wait 63 -> round-robin (blitr), 64 and 70 -> dcache.
    starve_trial(62, 4'd4);
    starve_trial(63, 4'd1);
    starve_trial(69, 4'd1);

    // Urgent VGA beats starving dcache; dcache wins the arbitration after.
    do_reset();
    blitw_request = 1'b1;
    @(negedge clock);
    expect_grant("ug_bw", 4'd3);
    dcache_request = 1'b1; blitr_request = 1'b1;
    repeat (70) @(negedge clock);
    vga_request = 1'b1; vga_urgent = 1'b1; blitw_request = 1'b0;
    finish_owner(4'd3);
    @(negedge clock);
    expect_grant("ug_vga", 4'd2);
    @(negedge clock);
    vga_request = 1'b0; vga_urgent = 1'b0;
    finish_owner(4'd2);
    @(negedge clock);
    expect_grant("ug_dc", 4'd1);
    dcache_request = 1'b0;
    finish_owner(4'd1);

    // Mismatched completion while BUSY is ignored and sticks in protocol_error.
    do_reset();
    blitr_request = 1'b1;
    @(negedge clock);
    expect_grant("pe_br", 4'd4);
    check_eq("pe_before", {31'd0, protocol_error}, 32'd0);
    sdram_complete = 4'd2;
    @(negedge clock);
    sdram_complete = 4'd0;
    expect_grant("pe_hold", 4'd4);
    check_eq("pe_set", {31'd0, protocol_error}, 32'd1);
    blitr_request = 1'b0;
    finish_owner(4'd4);
    check_eq("pe_sticky", {31'd0, protocol_error}, 32'd1);

    // Any completion while IDLE is also a protocol error.
    do_reset();
    check_eq("pei_clr", {31'd0, protocol_error}, 32'd0);
    sdram_complete = 4'd3;
    @(negedge clock);
    sdram_complete = 4'd0;
    check_eq("pei_set", {31'd0, protocol_error}, 32'd1);
    check_eq("pei_req", {31'd0, sdram_request}, 32'd0);

    // Late read word after complete, then reset mid-transaction.
    do_reset();
    dcache_write = 1'b0;
    dcache_request = 1'b1;
    @(negedge clock);
    expect_grant("lr_dc", 4'd1);
    sdram_complete = 4'd1; dcache_request = 1'b0;
    @(negedge clock);
    sdram_complete = 4'd0;
    sdram_valid = 4'd1; sdram_rdata = 32'hDEADBEEF;
    #1;
    check_eq("lr_idle", {31'd0, sdram_request}, 32'd0);
    check_eq("lr_dvalid", {31'd0, dcache_valid}, 32'd1);
    check_eq("lr_drdata", dcache_rdata, 32'hDEADBEEF);
    check_eq("lr_vrdata0", vga_rdata, 32'd0);
    check_eq("lr_bvalid0", {31'd0, blitr_valid}, 32'd0);
    sdram_valid = 4'd2;
    #1;
    check_eq("lr_vrdata", vga_rdata, 32'hDEADBEEF);
    check_eq("lr_drdata0", dcache_rdata, 32'd0);
    sdram_valid = 4'd4;
    #1;
    check_eq("lr_bvalid_rdata", {blitr_rdata[30:0], blitr_valid}, {31'h5EADBEEF, 1'b1});
    sdram_valid = 4'd0;
    blitr_request = 1'b1;
    @(negedge clock);
    expect_grant("ar_br", 4'd4);
    #2 reset = 1'b1;
    #1;
    check_eq("ar_req", {31'd0, sdram_request}, 32'd0);
    check_eq("ar_mst", {28'd0, sdram_master}, 32'd0);
    clear_reqs();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("ar_after", {31'd0, sdram_request}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_qos_arbiter.md
Name: sdram_qos_arbiter

Overview:
- Four-master SDRAM arbiter that replaces the fixed-priority scheme. Masters are dcache (ID 1), vga (ID 2), blitter write (ID 3) and blitter read (ID 4).
- Grants are registered and hold until the SDRAM controller reports completion for the owning ID.
- Policy order: VGA urgency first, then a dcache anti-starvation timer, then round-robin.
- Sits between the four bus masters and the SDRAM controller. Keeps the existing request/valid/complete handshake and the 4-bit master-ID tagging.

Parameters:
- MAX_WAIT, 64: dcache wait cycles after which dcache is forced to win the next arbitration.
- WAIT_W, 8: width of the dcache wait counter. Must satisfy 2^WAIT_W-1 >= MAX_WAIT.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dcache_request/write/burst  in  1 each  dcache request, direction, burst
- dcache_address  in  26  dcache word address
- dcache_wdata  in  32  dcache write data
- dcache_byte_en  in  4  dcache byte enables
- dcache_rdata  out  32  read data; 0 when dcache_valid=0
- dcache_valid, dcache_complete  out  1 each  dcache data strobe, end of transaction
- vga_request  in  1  VGA burst read request
- vga_address  in  26  VGA address
- vga_urgent  in  1  VGA line FIFO below low-water mark
- vga_rdata  out  32  VGA read data
- vga_valid, vga_complete  out  1 each  VGA data strobe, end of transaction
- blitw_request  in  1  blitter single write request
- blitw_address  in  26  blitter write address
- blitw_wdata  in  32  blitter write data
- blitw_byte_en  in  4  blitter byte enables
- blitw_complete  out  1  blitter write done
- blitr_request  in  1  blitter burst read request
- blitr_address  in  26  blitter read address
- blitr_rdata  out  32  blitter read data
- blitr_valid, blitr_complete  out  1 each  blitter read strobe, end of transaction
- sdram_request  out  1  owner present
- sdram_master  out  4  owner ID, 0 = none
- sdram_write/burst  out  1 each  forwarded from owner
- sdram_address  out  26  forwarded from owner
- sdram_wdata  out  32  forwarded from owner
- sdram_byte_en  out  4  forwarded from owner
- sdram_rdata  in  32  controller read data
- sdram_valid  in  4  ID of the master whose data word is valid, 0 = none
- sdram_complete  in  4  ID of the master completing, 0 = none
- protocol_error  out  1  sticky; set on a mismatched completion

Behaviour:
- FSM states: IDLE and BUSY. Registers: owner[3:0], rr_last[3:0], wait_cnt[WAIT_W-1:0], protocol_error.
- Reset (async): state=IDLE, owner=0, rr_last=4, wait_cnt=0, protocol_error=0. All outputs deassert immediately: sdram_request=0, sdram_master=0, all *_valid/*_complete=0, dcache_rdata=0.
- Reset mid-transaction abandons the owner. The controller is reset by the same signal.
- IDLE, any request high: winner selected combinationally and registered. Next cycle state=BUSY, owner=winner, rr_last=winner.
- Request-to-grant latency: request sampled in cycle N, sdram_request=1 in N+1.
- Winner priority:
  1. vga_urgent & vga_request → ID 2.
  2. dcache_request & wait_cnt>=MAX_WAIT → ID 1.
  3. Round-robin over requesting IDs in order 1,2,3,4, starting at rr_last+1 and wrapping 4→1.
- BUSY: sdram_request=1 and sdram_master=owner. Data outputs are muxed combinationally from the owner's inputs. Masters hold their inputs stable until complete.
- VGA and blitr mux to write=0, burst=1, byte_en=0. Blitw muxes to write=1, burst=0.
- In IDLE, data outputs are don't-care and sdram_master=0.
- BUSY, sdram_complete==owner: return to IDLE next cycle. One mandatory idle cycle separates transactions, so back-to-back grants are 2 cycles apart.
- BUSY, sdram_complete nonzero and !=owner: completion ignored, protocol_error set (sticky until reset). Same rule applies to any nonzero complete while IDLE.
- Response decode is pure combinational ID match:
  - dcache_valid = sdram_valid==1.
  - vga_valid = sdram_valid==2.
  - blitr_valid = sdram_valid==4.
  - Completes decode the same way; blitw_complete = sdram_complete==3.
- Valid decode is independent of owner, because a read's last word may arrive one cycle after complete.
- Non-dcache rdata outputs are 0 when not valid.
- wait_cnt:
  - increments each cycle dcache_request=1 and owner!=1, saturating at all-ones;
  - clears in the cycle dcache is granted;
  - clears whenever dcache_request=0.
- Simultaneous vga_urgent and starving dcache: VGA wins. wait_cnt keeps counting, so dcache wins the following arbitration.
- A request dropped before grant is simply not considered. Dropping after grant is a master protocol violation and is not checked.

Decomposition:
- Shared package sdram_pkg holds:
  - master ID constants MID_NONE=0, MID_DCACHE=1, MID_VGA=2, MID_BLITW=3, MID_BLITR=4;
  - address width 26 and data width 32.
- One sub-module, sdram_rr_pick: combinational 4-way round-robin picker. Inputs are the request vector and rr_last; outputs are the winner ID and a found flag.

Test Plan:
- Reset then dcache_request at N → sdram_request=1, sdram_master=1 at N+1. Controller sdram_complete=1 at N+5 → dcache_complete=1 at N+5, sdram_master=0 at N+6.
- All four requesting continuously, no urgency → grant order 1,2,3,4,1; each grant starts 2 cycles after the previous complete.
- VGA owns the bus, dcache waits 70 cycles with MAX_WAIT=64, VGA and blitr also requesting → next grant is ID 1; wait_cnt reads 0 the cycle after the grant.
- rr_last=1, dcache starving, vga_urgent=1 and vga_request=1 → VGA granted first, dcache granted next.
- BUSY with owner 4, sdram_complete=2 injected → state stays BUSY, protocol_error=1. Then sdram_complete=4 → IDLE; protocol_error stays 1.
- Owner 1 read with final sdram_valid=1 one cycle after complete → dcache_valid=1 with sdram_rdata=32'hDEADBEEF in IDLE. Assert reset during a later BUSY → sdram_request=0 in the same cycle.
